// File: rtl/noc_packetizer.sv
// Network-interface injector: turns (dest, len) requests plus a payload word stream
// into head/body/tail wormhole flits for a router's local input port.
module noc_packetizer #(
  parameter int LINK_WIDTH   = 8,
  parameter int MESH_ROWS    = 4,
  parameter int MESH_COLUMNS = 4,
  parameter int MAX_LEN      = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int DEST_W = $clog2(MESH_ROWS * MESH_COLUMNS),
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int PAY_W  = LINK_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [DEST_W-1:0]     pkt_dest,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [PAY_W-1:0]      data_in,
  output logic [LINK_WIDTH-1:0] out_flit,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic                  busy,
  output logic [15:0]           pkts_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t            state;
  logic              out_valid;
  logic              slot_free;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len_clamped;

  logic [PAY_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [PAY_W-1:0]  fifo_head;

  assign out_wr_en  = out_valid & ~out_full;
  assign slot_free  = ~out_valid | out_wr_en;
  assign pkt_ready  = (state == IDLE) & slot_free;
  assign busy       = (state == PAYLOAD) | out_valid;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign data_ready = ~fifo_full;
  assign push       = data_valid & ~fifo_full;
  assign pop        = (state == PAYLOAD) & ~fifo_empty & slot_free;
  assign fifo_head  = mem[rd_ptr];

  assign len_clamped = (pkt_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pkt_len;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pushed words are only visible through fifo_head on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The output register only changes when the router has taken (or never had) the
  // current flit, so a stalled flit stays stable on out_flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      rem       <= '0;
      pkts_sent <= '0;
    end else begin
      if (out_wr_en && out_flit[LINK_WIDTH-2]) begin
        pkts_sent <= pkts_sent + 16'd1;
      end
      case (state)
        IDLE: begin
          if (pkt_valid && pkt_ready) begin
            out_valid <= 1'b1;
            out_flit  <= {(len_clamped == '0) ? 2'b11 : 2'b10, PAY_W'(pkt_dest)};
            rem       <= len_clamped;
            state     <= (len_clamped == '0) ? IDLE : PAYLOAD;
          end else if (slot_free) begin
            out_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (pop) begin
            out_valid <= 1'b1;
            out_flit  <= {(rem == LEN_W'(1)) ? 2'b01 : 2'b00, fifo_head};
            rem       <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= IDLE;
            end
          end else if (slot_free) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer: expected flits are queued when requests and
// payload words are accepted, then compared as the DUT writes flits to the router.
module tb_noc_packetizer;

  localparam int LINK_WIDTH = 8;
  localparam int DEST_W     = 4;
  localparam int LEN_W      = 4;
  localparam int PAY_W      = 6;
  localparam int MAX_LEN    = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [DEST_W-1:0]     pkt_dest;
  logic [LEN_W-1:0]      pkt_len;
  logic                  data_valid;
  logic                  data_ready;
  logic [PAY_W-1:0]      data_in;
  logic [LINK_WIDTH-1:0] out_flit;
  logic                  out_wr_en;
  logic                  out_full;
  logic                  busy;
  logic [15:0]           pkts_sent;

  int checks   = 0;
  int failures = 0;

  logic [LINK_WIDTH-1:0] exp_q[$];
  logic [PAY_W-1:0]      data_model[$];
  int                    sb_rem = 0;
  logic [15:0]           model_sent = 16'd0;
  logic [LINK_WIDTH-1:0] mon_exp;

  always #5 clk = ~clk;

  noc_packetizer #(
    .LINK_WIDTH(LINK_WIDTH),
    .MESH_ROWS(4),
    .MESH_COLUMNS(4),
    .MAX_LEN(MAX_LEN),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_dest(pkt_dest),
    .pkt_len(pkt_len),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_in(data_in),
    .out_flit(out_flit),
    .out_wr_en(out_wr_en),
    .out_full(out_full),
    .busy(busy),
    .pkts_sent(pkts_sent)
  );

  // Every flit written to the router must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_flit got=%h exp=none", out_flit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_flit !== mon_exp) begin
          failures++;
          $display("[TB] FAIL sb_flit got=%h exp=%h", out_flit, mon_exp);
        end
        if (mon_exp[LINK_WIDTH-2]) model_sent = model_sent + 16'd1;
      end
    end
  end

  function automatic void sb_fill();
    logic [PAY_W-1:0] w;
    while (sb_rem > 0 && data_model.size() > 0) begin
      w = data_model.pop_front();
      sb_rem--;
      exp_q.push_back({(sb_rem == 0) ? 2'b01 : 2'b00, w});
    end
  endfunction

  task automatic push_word(input logic [PAY_W-1:0] w);
    int n = 0;
    data_valid = 1'b1;
    data_in    = w;
    @(negedge clk);
    while (data_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout got=data_ready_low exp=accept");
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (n < 100) begin
      data_model.push_back(w);
      sb_fill();
    end
  endtask

  task automatic send_req(input logic [DEST_W-1:0] dest, input logic [LEN_W-1:0] len);
    int n = 0;
    int l;
    pkt_valid = 1'b1;
    pkt_dest  = dest;
    pkt_len   = len;
    @(negedge clk);
    while (pkt_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_timeout got=pkt_ready_low exp=accept");
    end
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    if (n < 100) begin
      l = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      exp_q.push_back({(l == 0) ? 2'b11 : 2'b10, 2'b00, dest});
      sb_rem = l;
      sb_fill();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("[TB] FAIL idle_timeout got=busy=%b pending=%0d exp=idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pkt_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_pkt_ready got=%b exp=1", pkt_ready); end
    checks++; if (data_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_data_ready got=%b exp=1", data_ready); end
    checks++; if (out_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_wr_en got=%b exp=0", out_wr_en); end
    checks++; if (out_flit !== 8'h00) begin failures++; $display("[TB] FAIL rst_out_flit got=%h exp=00", out_flit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (pkts_sent !== 16'd0) begin failures++; $display("[TB] FAIL rst_pkts_sent got=%0d exp=0", pkts_sent); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    push_word(6'h01);
    push_word(6'h02);
    push_word(6'h03);
    send_req(4'd5, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL basic_stream cycle=%0d got=%b exp=1", i, out_wr_en); end
    end
    wait_idle();
    checks++; if (pkts_sent !== model_sent) begin failures++; $display("[TB] FAIL basic_pkts_sent got=%0d exp=%0d", pkts_sent, model_sent); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    push_word(6'h01);
    push_word(6'h02);
    push_word(6'h03);
    send_req(4'd5, 4'd3);
    @(negedge clk);
    checks++; if (out_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL bp_head_wr got=%b exp=1", out_wr_en); end
    @(posedge clk);
    #1;
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_stall_wr cycle=%0d got=%b exp=0", i, out_wr_en); end
      checks++; if (out_flit !== 8'h01) begin failures++; $display("[TB] FAIL bp_hold_flit cycle=%0d got=%h exp=01", i, out_flit); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL bp_busy cycle=%0d got=%b exp=1", i, busy); end
      @(posedge clk);
      #1;
      if (i == 2) out_full = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL bp_resume cycle=%0d got=%b exp=1", i, out_wr_en); end
    end
    wait_idle();
    checks++; if (pkts_sent !== model_sent) begin failures++; $display("[TB] FAIL bp_pkts_sent got=%0d exp=%0d", pkts_sent, model_sent); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_len();
    push_word(6'h2A);
    out_full = 1'b1;
    @(negedge clk);
    checks++; if (pkt_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_full_glitch got=%b exp=1", pkt_ready); end
    @(posedge clk);
    #1;
    out_full = 1'b0;
    send_req(4'd9, 4'd0);
    @(negedge clk);
    checks++; if (out_flit !== 8'hC9) begin failures++; $display("[TB] FAIL zlen_flit got=%h exp=c9", out_flit); end
    @(negedge clk);
    checks++; if (out_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL zlen_single got=%b exp=0", out_wr_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL zlen_busy got=%b exp=0", busy); end
    checks++; if (pkts_sent !== model_sent) begin failures++; $display("[TB] FAIL zlen_pkts_sent got=%0d exp=%0d", pkts_sent, model_sent); end
    @(posedge clk);
    #1;
    send_req(4'd1, 4'd1);
    wait_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_clamp();
    send_req(4'd7, 4'd12);
    for (int i = 0; i < 8; i++) begin
      push_word(6'(6'h20 + i));
    end
    wait_idle();
    checks++; if (pkts_sent !== model_sent) begin failures++; $display("[TB] FAIL clamp_pkts_sent got=%0d exp=%0d", pkts_sent, model_sent); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      push_word(6'(6'h11 + i));
      @(negedge clk);
      checks++;
      if (data_ready !== (i < 3)) begin failures++; $display("[TB] FAIL fifo_fill push=%0d got=%b exp=%b", i, data_ready, (i < 3)); end
      @(posedge clk);
      #1;
    end
    data_valid = 1'b1;
    data_in    = 6'h3F;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (data_ready !== 1'b0) begin failures++; $display("[TB] FAIL fifo_full_ready cycle=%0d got=%b exp=0", i, data_ready); end
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    send_req(4'd4, 4'd4);
    @(negedge clk);
    checks++; if (data_ready !== 1'b0) begin failures++; $display("[TB] FAIL fifo_before_pop got=%b exp=0", data_ready); end
    @(negedge clk);
    checks++; if (data_ready !== 1'b1) begin failures++; $display("[TB] FAIL fifo_after_pop got=%b exp=1", data_ready); end
    wait_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] start_sent;
    push_word(6'h01);
    push_word(6'h02);
    push_word(6'h03);
    start_sent = model_sent;
    fork
      begin
        send_req(4'd2, 4'd1);
        send_req(4'd3, 4'd2);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (out_wr_en !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (out_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL b2b_gap flit=%0d got=%b exp=1", i + 1, out_wr_en); end
        end
      end
    join
    wait_idle();
    checks++; if (pkts_sent !== start_sent + 16'd2) begin failures++; $display("[TB] FAIL b2b_pkts_sent got=%0d exp=%0d", pkts_sent, start_sent + 16'd2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_packet();
    push_word(6'h01);
    push_word(6'h02);
    push_word(6'h03);
    send_req(4'd6, 4'd3);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    data_model.delete();
    sb_rem     = 0;
    model_sent = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_wr got=%b exp=0", out_wr_en); end
    checks++; if (data_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_data_ready got=%b exp=1", data_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (pkt_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_pkt_ready got=%b exp=1", pkt_ready); end
    checks++; if (pkts_sent !== 16'd0) begin failures++; $display("[TB] FAIL mid_rst_pkts_sent got=%0d exp=0", pkts_sent); end
    @(posedge clk);
    #1;
    send_req(4'd8, 4'd1);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_fifo_empty got=busy=%b exp=1", busy); end
    @(posedge clk);
    #1;
    push_word(6'h15);
    wait_idle();
    checks++; if (pkts_sent !== model_sent) begin failures++; $display("[TB] FAIL mid_rst_after got=%0d exp=%0d", pkts_sent, model_sent); end
  endtask

  initial begin
    rst        = 1'b1;
    pkt_valid  = 1'b0;
    pkt_dest   = '0;
    pkt_len    = '0;
    data_valid = 1'b0;
    data_in    = '0;
    out_full   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
